// File: rtl/spi_slave_rx_if.sv
// rtl/spi_slave_rx_if.sv - SPI pin and receive-FIFO signal bundle for spi_slave_rx
interface spi_slave_rx_if #(
  parameter int WORD_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
);
  logic                          SPIClk;
  logic                          SPIData;
  logic                          SPICS_n;
  logic [WORD_WIDTH-1:0]         data_out;
  logic                          data_valid;
  logic                          data_read;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overrun;
  logic                          frame_error;
  logic                          clear_flags;

  modport slave (
    input  SPIClk, SPIData, SPICS_n, data_read, clear_flags,
    output data_out, data_valid, fifo_count, overrun, frame_error
  );

  modport master (
    output SPIClk, SPIData, SPICS_n, data_read, clear_flags,
    input  data_out, data_valid, fifo_count, overrun, frame_error
  );
endinterface

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - receive-only SPI slave with selectable mode/bit order and word FIFO
module spi_slave_rx #(
  parameter int          WORD_WIDTH = 16,
  parameter logic [15:0] IDLETIME   = 16'h1FF,
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset,
  spi_slave_rx_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(WORD_WIDTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t                 state;
  logic                   clk_s1, clk_s2, clk_prev;
  logic                   data_s1, data_s2;
  logic                   cs_s1, cs_s2;
  logic [BW-1:0]          bit_cnt;
  logic [16:0]            idle_cnt;
  logic [WORD_WIDTH-1:0]  shift_reg;
  logic [WORD_WIDTH-1:0]  shifted;

  logic [WORD_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic                   overrun_q, frame_error_q;

  logic sclk_edge, lead_edge, trail_edge, sample;
  logic timeout, push, frame_evt, do_pop, do_push, overrun_evt;

  // Edges are judged from the synchronised level against its previous value
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1   <= CPOL;
      clk_s2   <= CPOL;
      clk_prev <= CPOL;
      data_s1  <= 1'b0;
      data_s2  <= 1'b0;
      cs_s1    <= 1'b1;
      cs_s2    <= 1'b1;
    end else begin
      clk_s1   <= bus.SPIClk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= bus.SPIData;
      data_s2  <= data_s1;
      cs_s1    <= bus.SPICS_n;
      cs_s2    <= cs_s1;
    end
  end

  assign sclk_edge  = (clk_s2 != clk_prev);
  assign lead_edge  = sclk_edge && (clk_prev == CPOL);
  assign trail_edge = sclk_edge && (clk_s2 == CPOL);
  assign sample     = CPHA ? trail_edge : lead_edge;

  always_comb begin
    shifted = shift_reg;
    if (MSB_FIRST)
      shifted = {shift_reg[WORD_WIDTH-2:0], data_s2};
    else
      shifted = {data_s2, shift_reg[WORD_WIDTH-1:1]};
  end

  // Chip-select abort outranks the stall timeout, which outranks word completion
  assign timeout   = (idle_cnt > {1'b0, IDLETIME});
  assign frame_evt = (state == RECV) && (cs_s2 || timeout);
  assign push      = (state == RECV) && !cs_s2 && !timeout && sample && (bit_cnt == LAST_BIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!cs_s2 && (clk_s2 == CPOL)) begin
            state    <= RECV;
            bit_cnt  <= '0;
            idle_cnt <= '0;
          end
        end
        RECV: begin
          if (cs_s2 || timeout) begin
            state <= IDLE;
          end else begin
            idle_cnt <= sclk_edge ? 17'd0 : idle_cnt + 17'd1;
            if (sample) begin
              shift_reg <= shifted;
              if (bit_cnt == LAST_BIT) begin
                state   <= DONE;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (CPHA || (clk_s2 == CPOL))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign do_pop      = bus.data_read && (count != '0);
  assign do_push     = push && ((count != FULL_CNT) || do_pop);
  assign overrun_evt = push && (count == FULL_CNT) && !do_pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shifted;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  // A fresh error event beats a simultaneous clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      if (overrun_evt)
        overrun_q <= 1'b1;
      else if (bus.clear_flags)
        overrun_q <= 1'b0;
      if (frame_evt)
        frame_error_q <= 1'b1;
      else if (bus.clear_flags)
        frame_error_q <= 1'b0;
    end
  end

  assign bus.data_out    = mem[rd_ptr];
  assign bus.data_valid  = (count != '0);
  assign bus.fifo_count  = count;
  assign bus.overrun     = overrun_q;
  assign bus.frame_error = frame_error_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - directed self-checking bench for spi_slave_rx
module tb_spi_slave_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  spi_slave_rx_if #(.WORD_WIDTH(16), .FIFO_DEPTH(4)) bus0 ();
  spi_slave_rx_if #(.WORD_WIDTH(24), .FIFO_DEPTH(4)) bus1 ();

  spi_slave_rx dut0 (.clock(clk), .reset(rst_n), .bus(bus0.slave));

  spi_slave_rx #(
    .WORD_WIDTH(24), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1), .FIFO_DEPTH(4)
  ) dut1 (.clock(clk), .reset(rst_n), .bus(bus1.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs0_low();
    bus0.SPICS_n = 1'b0;
    wait_clk(5);
  endtask

  // Mode 0, LSB first; optionally releases CS while SPIClk is still high after the last bit
  task automatic send0(input logic [31:0] w, input int n, input bit release_cs);
    for (int i = 0; i < n; i++) begin
      bus0.SPIData = w[i];
      wait_clk(8);
      bus0.SPIClk = 1'b1;
      wait_clk(8);
      if (release_cs && (i == n - 1)) begin
        bus0.SPICS_n = 1'b1;
        wait_clk(4);
      end
      bus0.SPIClk = 1'b0;
    end
    wait_clk(4);
  endtask

  // Mode 3, MSB first; CS rises one clock after the final sampling edge
  task automatic send1(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bus1.SPIClk  = 1'b0;
      bus1.SPIData = w[n-1-i];
      wait_clk(8);
      bus1.SPIClk = 1'b1;
      if (i == n - 1) begin
        wait_clk(1);
        bus1.SPICS_n = 1'b1;
        wait_clk(7);
      end else begin
        wait_clk(8);
      end
    end
    wait_clk(4);
  endtask

  task automatic pop0();
    bus0.data_read = 1'b1;
    wait_clk(1);
    bus0.data_read = 1'b0;
  endtask

  task automatic pulse_clear0();
    bus0.clear_flags = 1'b1;
    wait_clk(1);
    bus0.clear_flags = 1'b0;
  endtask

  logic [15:0] words [5];

  initial begin
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    words[3] = 16'h4444; words[4] = 16'h5555;
    bus0.SPIClk = 1'b0; bus0.SPIData = 1'b0; bus0.SPICS_n = 1'b1;
    bus0.data_read = 1'b0; bus0.clear_flags = 1'b0;
    bus1.SPIClk = 1'b1; bus1.SPIData = 1'b0; bus1.SPICS_n = 1'b1;
    bus1.data_read = 1'b0; bus1.clear_flags = 1'b0;

    wait_clk(3);
    check("rst_valid", bus0.data_valid, 0);
    check("rst_count", bus0.fifo_count, 0);
    check("rst_data", bus0.data_out, 0);
    check("rst_overrun", bus0.overrun, 0);
    check("rst_ferr", bus0.frame_error, 0);
    rst_n = 1'b1;
    wait_clk(3);

    cs0_low();
    send0(32'hA5C3, 16, 1'b1);
    check("m0_valid", bus0.data_valid, 1);
    check("m0_data", bus0.data_out, 32'hA5C3);
    check("m0_count", bus0.fifo_count, 1);
    check("m0_ferr", bus0.frame_error, 0);
    pop0();
    check("m0_pop_valid", bus0.data_valid, 0);

    bus1.SPICS_n = 1'b0;
    wait_clk(5);
    send1(32'h123456, 24);
    check("m3_valid", bus1.data_valid, 1);
    check("m3_data", bus1.data_out, 32'h123456);
    check("m3_ferr", bus1.frame_error, 0);
    bus1.data_read = 1'b1;
    wait_clk(1);
    bus1.data_read = 1'b0;
    check("m3_pop_valid", bus1.data_valid, 0);

    cs0_low();
    for (int i = 0; i < 5; i++)
      send0({16'h0, words[i]}, 16, i == 4);
    check("ovr_count", bus0.fifo_count, 4);
    check("ovr_flag", bus0.overrun, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovr_word%0d", i), bus0.data_out, {16'h0, words[i]});
      pop0();
    end
    check("ovr_empty", bus0.data_valid, 0);
    pulse_clear0();
    check("ovr_clear", bus0.overrun, 0);

    cs0_low();
    send0(32'h007F, 7, 1'b0);
    wait_clk(16'h240);
    check("to_ferr", bus0.frame_error, 1);
    check("to_count", bus0.fifo_count, 0);
    bus0.SPICS_n = 1'b1;
    wait_clk(10);
    pulse_clear0();
    check("to_clear", bus0.frame_error, 0);
    cs0_low();
    send0(32'hBEEF, 16, 1'b1);
    check("to_next_data", bus0.data_out, 32'hBEEF);
    check("to_next_count", bus0.fifo_count, 1);
    pop0();

    cs0_low();
    send0(32'h01FF, 9, 1'b0);
    bus0.SPICS_n = 1'b1;
    wait_clk(6);
    check("cs_ferr", bus0.frame_error, 1);
    check("cs_count", bus0.fifo_count, 0);
    pulse_clear0();
    check("cs_clear", bus0.frame_error, 0);

    cs0_low();
    send0(32'hC001, 16, 1'b0);
    send0(32'hD002, 16, 1'b0);
    send0(32'h0015, 5, 1'b0);
    check("rr_pre_count", bus0.fifo_count, 2);
    check("rr_pre_data", bus0.data_out, 32'hC001);
    rst_n = 1'b0;
    bus0.SPICS_n = 1'b1;
    #1;
    check("rr_valid", bus0.data_valid, 0);
    check("rr_count", bus0.fifo_count, 0);
    check("rr_data", bus0.data_out, 0);
    check("rr_ferr", bus0.frame_error, 0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
    cs0_low();
    send0(32'h5A5A, 16, 1'b1);
    check("rr_next_data", bus0.data_out, 32'h5A5A);
    check("rr_next_count", bus0.fifo_count, 1);
    check("rr_next_ferr", bus0.frame_error, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
